// File: rtl/ula_seq_pkg.sv
// Shared constants for the ULA command sequencer: default widths, FSM state
// encoding and the opcode set.
package ula_seq_pkg;

    localparam int WIDTH_D = 8;
    localparam int OPW_D   = 3;
    localparam int LAT_D   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_0 = 3'b000;
    localparam logic [2:0] OP_1 = 3'b001;
    localparam logic [2:0] OP_2 = 3'b010;
    localparam logic [2:0] OP_3 = 3'b011;
    localparam logic [2:0] OP_4 = 3'b100;
    localparam logic [2:0] OP_5 = 3'b101;
    localparam logic [2:0] OP_6 = 3'b110;
    localparam logic [2:0] OP_7 = 3'b111;

endpackage

// File: rtl/ula_seq_if.sv
// Command and result handshakes between a command source and the ULA sequencer.
interface ula_seq_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_acc;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_flag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, res_ready,
        input  cmd_ready, res_valid, res_data, res_flag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, res_ready,
        output cmd_ready, res_valid, res_data, res_flag
    );
endinterface

// File: rtl/ula_seq.sv
// Single-command-in-flight sequencer: registers ULA operands, waits LAT cycles
// for the ULA to settle, then captures the result into a valid/ready port.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int OPW   = OPW_D,
    parameter int LAT   = LAT_D
) (
    input  logic             clk,
    input  logic             clr,
    ula_seq_if.slave         bus,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [OPW-1:0]   ula_op,
    input  logic [WIDTH-1:0] ula_s,
    input  logic             ula_flag,
    output logic             busy
);

    localparam logic [3:0] LAT_C = 4'(LAT);

    state_t           state, nxt;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_q;
    logic             flag_q;
    logic             accept;
    logic             capture;

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt           = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (bus.cmd_valid) begin
                    accept = 1'b1;
                    nxt    = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture = 1'b1;
                    nxt     = DONE;
                end
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Operands stay frozen outside an accept so the ULA output is stable at capture.
    always_ff @(posedge clk) begin
        if (clr) begin
            ula_a  <= '0;
            ula_b  <= '0;
            ula_op <= '0;
            cnt    <= '0;
            acc    <= '0;
            res_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (accept) begin
                ula_a  <= bus.cmd_acc ? acc : bus.cmd_a;
                ula_b  <= bus.cmd_b;
                ula_op <= bus.cmd_op;
                cnt    <= LAT_C;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                res_q  <= ula_s;
                flag_q <= ula_flag;
                acc    <= ula_s;
            end
        end
    end

    assign bus.res_data = res_q;
    assign bus.res_flag = flag_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq with a registered ULA stub and a result scoreboard.
module tb_ula_seq;
    import ula_seq_pkg::*;

    localparam int LAT = 1;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] ula_a, ula_b, ula_s;
    logic [2:0] ula_op;
    logic       ula_flag, busy;

    ula_seq_if #(.WIDTH(8), .OPW(3)) bus ();

    ula_seq #(.WIDTH(8), .OPW(3), .LAT(LAT)) u_dut (
        .clk(clk), .clr(clr), .bus(bus),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
        .ula_s(ula_s), .ula_flag(ula_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub ULA model: bit 8 is the flag (carry/borrow for add/sub, zero otherwise).
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        logic [8:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~a};
            3'd6:    r = {1'b0, a << 1};
            default: r = {1'b0, b};
        endcase
        if (op > 3'd1) r[8] = (r[7:0] == 8'd0);
        return r;
    endfunction

    always @(posedge clk) begin
        if (clr) {ula_flag, ula_s} <= 9'd0;
        else     {ula_flag, ula_s} <= model(ula_a, ula_b, ula_op);
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [8:0] sb[$];
    logic [7:0] macc = 8'd0;
    logic       acc_seen;
    int         acc_cyc;
    logic [7:0] last_aeff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample pre-edge handshakes at the falling edge; scoreboard push/pop here.
    task automatic mon();
        logic [8:0] e;
        logic [7:0] aeff;
        acc_seen = 1'b0;
        if (clr) begin
            sb.delete();
            macc = 8'd0;
        end else begin
            if (bus.res_valid) chk("valid_without_pending", 32'(sb.size() != 0), 32'd1);
            if (bus.res_valid && bus.res_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_data", 32'(bus.res_data), 32'(e[7:0]));
                chk("res_flag", 32'(bus.res_flag), 32'(e[8]));
                macc = e[7:0];
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                aeff = bus.cmd_acc ? macc : bus.cmd_a;
                sb.push_back(model(aeff, bus.cmd_b, bus.cmd_op));
                acc_seen  = 1'b1;
                acc_cyc   = cyc;
                last_aeff = aeff;
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, prev, budget;
        logic [2:0] op;
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'h55; bus.cmd_b = 8'hAA;
        bus.cmd_op = 3'd3; bus.cmd_acc = 1'b0; bus.res_ready = 1'b0;

        // Reset with a command presented: nothing may be accepted
        step(); step();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_ula_a", 32'(ula_a), 32'd0);
        chk("rst_ula_b", 32'(ula_b), 32'd0);
        chk("rst_ula_op", 32'(ula_op), 32'd0);
        chk("rst_acc", 32'(u_dut.acc), 32'd0);
        clr = 1'b0; bus.cmd_valid = 1'b0;
        step();
        chk("idle_after_rst", 32'(busy), 32'd0);

        // Single add
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'h2B; bus.cmd_b = 8'h71; bus.cmd_op = OP_0;
        step();
        bus.cmd_valid = 1'b0;
        chk("add_ula_a", 32'(ula_a), 32'h2B);
        chk("add_ula_b", 32'(ula_b), 32'h71);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("add_valid_early", 32'(bus.res_valid), 32'd0);
        step();
        chk("add_valid", 32'(bus.res_valid), 32'd1);
        chk("add_data", 32'(bus.res_data), 32'h9C);
        chk("add_flag", 32'(bus.res_flag), 32'd0);

        // Backpressure, with an ignored command pulse
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin bus.cmd_valid = 1'b1; bus.cmd_a = 8'h11; end
            if (i == 3) bus.cmd_valid = 1'b0;
            step();
            chk("bp_valid", 32'(bus.res_valid), 32'd1);
            chk("bp_data", 32'(bus.res_data), 32'h9C);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("bp_no_accept", 32'(acc_seen), 32'd0);
        end
        chk("bp_ula_a_held", 32'(ula_a), 32'h2B);
        bus.res_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(bus.res_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.cmd_ready), 32'd1);
        chk("sb_drained_1", 32'(sb.size()), 32'd0);

        // Accumulate: operand a comes from the previous result
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_acc = 1'b1; bus.cmd_a = 8'hFF;
        bus.cmd_b = 8'h01; bus.cmd_op = OP_0;
        step();
        bus.cmd_valid = 1'b0; bus.cmd_acc = 1'b0;
        chk("acc_ula_a", 32'(ula_a), 32'h9C);
        step(); step();
        chk("acc_valid", 32'(bus.res_valid), 32'd1);
        chk("acc_data", 32'(bus.res_data), 32'h9D);
        chk("acc_reg", 32'(u_dut.acc), 32'h9D);
        bus.res_ready = 1'b1;
        step();

        // Reset while waiting on the ULA
        bus.cmd_valid = 1'b1; bus.cmd_a = 8'h10; bus.cmd_b = 8'h20; bus.cmd_op = OP_4;
        step();
        bus.cmd_valid = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_acc", 32'(u_dut.acc), 32'd0);
        chk("mid_ula", 32'({ula_a, ula_b, 5'(ula_op)}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_no_valid", 32'(bus.res_valid), 32'd0);
        end

        // Opcode sweep with cmd_valid held
        n = 0; prev = 0; budget = 200; op = 3'd0;
        bus.res_ready = 1'b1; bus.cmd_valid = 1'b1;
        bus.cmd_a = 8'h2B; bus.cmd_b = 8'h71; bus.cmd_op = op;
        while (n < 8 && budget > 0) begin
            step();
            budget--;
            if (acc_seen) begin
                chk("sweep_ula_op", 32'(ula_op), 32'(op));
                chk("sweep_ula_a", 32'(ula_a), 32'(last_aeff));
                if (n > 0) chk("sweep_spacing", 32'(acc_cyc - prev), 32'(LAT + 3));
                prev = acc_cyc;
                n++;
                op = op + 3'd1;
                bus.cmd_op = op;
                if (n == 8) bus.cmd_valid = 1'b0;
            end
        end
        chk("sweep_accepts", 32'(n), 32'd8);
        for (int i = 0; i < LAT + 4; i++) step();
        chk("sweep_sb_empty", 32'(sb.size()), 32'd0);
        chk("sweep_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
